// File: rtl/alu_pkg.sv
// Shared widths and ALU opcodes for the 8-bit register/ALU datapath.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_ADDR_W = 3;
    localparam int ALU_OP_W   = 3;

    localparam logic [ALU_OP_W-1:0] ALU_FWD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;

endpackage

// File: rtl/alu_reg_file_alu_core.sv
// Combinational ALU: forward, add (carry dropped), and, or; reserved ops give 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [DATA_W-1:0]   DATA1,
    input  logic [DATA_W-1:0]   DATA2,
    input  logic [ALU_OP_W-1:0] ALUOP,
    output logic [DATA_W-1:0]   RESULT
);

    always_comb begin
        RESULT = '0;
        case (ALUOP)
            ALU_FWD: RESULT = DATA2;
            ALU_ADD: RESULT = DATA1 + DATA2;
            ALU_AND: RESULT = DATA1 & DATA2;
            ALU_OR:  RESULT = DATA1 | DATA2;
            default: RESULT = '0;
        endcase
    end

endmodule

// File: rtl/alu_reg_file.sv
// 8x8 register file (2R/1W, no bypass) whose write data is the ALU result.
module alu_reg_file
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int ADDR_W = ALU_ADDR_W
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                WRITEENABLE,
    input  logic [ADDR_W-1:0]   WRITEREG,
    input  logic [ADDR_W-1:0]   READREG1,
    input  logic [ADDR_W-1:0]   READREG2,
    input  logic [ALU_OP_W-1:0] ALUOP,
    input  logic [DATA_W-1:0]   DATA2,
    output logic [DATA_W-1:0]   REGOUT1,
    output logic [DATA_W-1:0]   REGOUT2,
    output logic [DATA_W-1:0]   ALU_RESULT
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0][DATA_W-1:0] regs_d;

    assign REGOUT1 = regs_q[READREG1];
    assign REGOUT2 = regs_q[READREG2];

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu (
        .DATA1  (REGOUT1),
        .DATA2  (DATA2),
        .ALUOP  (ALUOP),
        .RESULT (ALU_RESULT)
    );

    // Operand A comes from regs_q, so a self-referencing write settles once per edge.
    always_comb begin
        regs_d = regs_q;
        if (WRITEENABLE) begin
            regs_d[WRITEREG] = ALU_RESULT;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_alu_reg_file.sv
// Directed self-checking bench for alu_reg_file.
module tb_alu_reg_file;
    import alu_pkg::*;

    logic       CLK;
    logic       RESET;
    logic       WRITEENABLE;
    logic [2:0] WRITEREG;
    logic [2:0] READREG1;
    logic [2:0] READREG2;
    logic [2:0] ALUOP;
    logic [7:0] DATA2;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;
    logic [7:0] ALU_RESULT;

    int checks   = 0;
    int failures = 0;

    alu_reg_file dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .WRITEENABLE (WRITEENABLE),
        .WRITEREG    (WRITEREG),
        .READREG1    (READREG1),
        .READREG2    (READREG2),
        .ALUOP       (ALUOP),
        .DATA2       (DATA2),
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .ALU_RESULT  (ALU_RESULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [2:0] r, input logic [7:0] v);
        ALUOP       = ALU_FWD;
        DATA2       = v;
        WRITEREG    = r;
        WRITEENABLE = 1'b1;
        tick();
        WRITEENABLE = 1'b0;
    endtask

    initial begin
        RESET       = 1'b1;
        WRITEENABLE = 1'b0;
        WRITEREG    = 3'd0;
        READREG1    = 3'd0;
        READREG2    = 3'd7;
        ALUOP       = ALU_FWD;
        DATA2       = 8'h00;
        tick();
        tick();
        check("rst_r0", REGOUT1, 8'h00);
        check("rst_r7", REGOUT2, 8'h00);
        RESET = 1'b0;
        tick();

        // async reset mid-cycle, then blocked write
        load(3'd3, 8'h5A);
        READREG1 = 3'd3;
        #1;
        check("r3_pre_rst", REGOUT1, 8'h5A);
        #1;
        RESET = 1'b1;
        #1;
        check("async_rst", REGOUT1, 8'h00);
        ALUOP       = ALU_FWD;
        DATA2       = 8'h77;
        WRITEREG    = 3'd3;
        WRITEENABLE = 1'b1;
        tick();
        check("rst_blocks_wr", REGOUT1, 8'h00);
        WRITEENABLE = 1'b0;
        RESET       = 1'b0;
        tick();

        // load/forward with read-during-write ordering
        READREG2    = 3'd4;
        ALUOP       = ALU_FWD;
        DATA2       = 8'h05;
        WRITEREG    = 3'd4;
        WRITEENABLE = 1'b1;
        #1;
        check("fwd_result", ALU_RESULT, 8'h05);
        check("r4_old", REGOUT2, 8'h00);
        tick();
        WRITEENABLE = 1'b0;
        check("r4_new", REGOUT2, 8'h05);

        // add with wrap
        load(3'd1, 8'hF0);
        load(3'd2, 8'h20);
        READREG1    = 3'd1;
        READREG2    = 3'd5;
        ALUOP       = ALU_ADD;
        DATA2       = 8'h20;
        WRITEREG    = 3'd5;
        WRITEENABLE = 1'b1;
        #1;
        check("add_wrap", ALU_RESULT, 8'h10);
        tick();
        WRITEENABLE = 1'b0;
        check("r5_add", REGOUT2, 8'h10);

        // subtract via negated operand
        load(3'd1, 8'h09);
        ALUOP = ALU_ADD;
        DATA2 = 8'hFD;
        #1;
        check("sub_9m3", ALU_RESULT, 8'h06);
        load(3'd1, 8'h02);
        ALUOP = ALU_ADD;
        DATA2 = 8'hFB;
        #1;
        check("sub_2m5", ALU_RESULT, 8'hFD);

        // logic ops and reserved codes
        load(3'd1, 8'hCC);
        DATA2 = 8'hAA;
        ALUOP = ALU_AND;
        #1;
        check("and", ALU_RESULT, 8'h88);
        ALUOP = ALU_OR;
        #1;
        check("or", ALU_RESULT, 8'hEE);
        ALUOP = 3'b101;
        #1;
        check("rsv_101", ALU_RESULT, 8'h00);
        ALUOP = 3'b111;
        #1;
        check("rsv_111", ALU_RESULT, 8'h00);
        ALUOP = 3'b100;
        #1;
        check("rsv_100", ALU_RESULT, 8'h00);

        // write-enable gating
        load(3'd6, 8'h33);
        READREG2    = 3'd6;
        ALUOP       = ALU_FWD;
        DATA2       = 8'h77;
        WRITEREG    = 3'd6;
        WRITEENABLE = 1'b0;
        #1;
        check("we0_result", ALU_RESULT, 8'h77);
        tick();
        check("we0_r6", REGOUT2, 8'h33);

        // r0 is writable, both ports on one register
        load(3'd0, 8'hA5);
        READREG1 = 3'd0;
        READREG2 = 3'd0;
        #1;
        check("r0_p1", REGOUT1, 8'hA5);
        check("r0_p2", REGOUT2, 8'hA5);

        // self-referencing increment
        load(3'd2, 8'h01);
        READREG1    = 3'd2;
        WRITEREG    = 3'd2;
        ALUOP       = ALU_ADD;
        DATA2       = 8'h01;
        WRITEENABLE = 1'b1;
        tick();
        check("self_inc1", REGOUT1, 8'h02);
        tick();
        check("self_inc2", REGOUT1, 8'h03);
        tick();
        check("self_inc3", REGOUT1, 8'h04);
        WRITEENABLE = 1'b0;
        tick();
        check("self_hold", REGOUT1, 8'h04);

        // earlier registers untouched by later traffic
        READREG1 = 3'd5;
        READREG2 = 3'd4;
        #1;
        check("r5_keep", REGOUT1, 8'h10);
        check("r4_keep", REGOUT2, 8'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
